// File: rtl/full_adder_if.sv
// Operand, result and valid signals of the full_adder, grouped for port connection.
// The optional overflow outputs (ovf, ovf_q) exist only when FULL_ADDER_OVERFLOW_EN is defined.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             in_valid;

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic             ovf;
  logic             ovf_q;

  // Producer of operands / consumer of results
  modport master (
    output a, b, c, in_valid,
    input  sum, cout, sum_q, cout_q, out_valid, ovf, ovf_q
  );

  // The adder itself
  modport slave (
    input  a, b, c, in_valid,
    output sum, cout, sum_q, cout_q, out_valid, ovf, ovf_q
  );
`else
  // Producer of operands / consumer of results
  modport master (
    output a, b, c, in_valid,
    input  sum, cout, sum_q, cout_q, out_valid
  );

  // The adder itself
  modport slave (
    input  a, b, c, in_valid,
    output sum, cout, sum_q, cout_q, out_valid
  );
`endif

endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder with carry-in/carry-out, a combinational result and a
// registered copy qualified by a valid flag for downstream pipelines.
// Optional signed-overflow outputs are enabled by defining FULL_ADDER_OVERFLOW_EN.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  full_adder_if.slave bus
);

  // Reject widths outside the supported range at elaboration time
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("full_adder: WIDTH must be in 1..64");
  end

  // carry[i] is the carry into cell i; carry[WIDTH] is the carry-out
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = bus.c;

  // Ripple chain of 1-bit full-adder cells; plain gates so X/Z propagate unmasked
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_c[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
    assign carry[i + 1] = (bus.a[i] & bus.b[i]) |
                          (bus.a[i] & carry[i]) |
                          (bus.b[i] & carry[i]);
  end

  assign bus.sum  = sum_c;
  assign bus.cout = carry[WIDTH];

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             valid_d, valid_q;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic ovf_c;
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it
  assign ovf_c   = carry[WIDTH] ^ carry[WIDTH-1];
  assign bus.ovf = ovf_c;
`endif

  // Capture the combinational result when in_valid is set, otherwise hold it
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = bus.in_valid;
`ifdef FULL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    if (bus.in_valid) begin
      sum_d  = sum_c;
      cout_d = carry[WIDTH];
`ifdef FULL_ADDER_OVERFLOW_EN
      ovf_d  = ovf_c;
`endif
    end
  end

  // Output registers; asynchronous reset discards any captured result at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
`ifdef FULL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.sum_q     = sum_q;
  assign bus.cout_q    = cout_q;
  assign bus.out_valid = valid_q;
`ifdef FULL_ADDER_OVERFLOW_EN
  assign bus.ovf_q     = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed tables for WIDTH=1 and WIDTH=8,
// hand-written registered-path/reset sequences and a random WIDTH=8 run.
module tb_full_adder;

  logic clk;
  logic rst_n;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic sum;
    logic cout;
    logic ovf;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec8_t;

  vec1_t tab1[8];
  vec8_t tab8[6];

  logic [7:0] ra, rb;
  logic       rc, rv;
  logic [8:0] ref9;
  logic [7:0] exp_sq;
  logic       exp_cq;
  logic       exp_ovf, exp_ovq;

  initial begin
    // a, b, c, sum, cout, ovf (ovf = k1 ^ k0 = cout ^ c)
    tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tab1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tab1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tab1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tab1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    tab8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tab8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tab8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tab8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tab8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tab8[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.in_valid = 1'b0;
    bus8.a = 8'h0; bus8.b = 8'h0; bus8.c = 1'b0; bus8.in_valid = 1'b0;

    // Reset state
    #2;
    check("rst_sum_q1", bus1.sum_q, 0);
    check("rst_cout_q1", bus1.cout_q, 0);
    check("rst_valid1", bus1.out_valid, 0);
    check("rst_sum_q8", bus8.sum_q, 0);
    check("rst_valid8", bus8.out_valid, 0);
`ifdef FULL_ADDER_OVERFLOW_EN
    check("rst_ovf_q8", bus8.ovf_q, 0);
`endif
    #10;
    rst_n = 1'b1;

    // WIDTH=1 truth table, combinational only
    for (int i = 0; i < 8; i++) begin
      bus1.a = tab1[i].a; bus1.b = tab1[i].b; bus1.c = tab1[i].c;
      #1;
      check($sformatf("w1_sum[%0d]", i), bus1.sum, tab1[i].sum);
      check($sformatf("w1_cout[%0d]", i), bus1.cout, tab1[i].cout);
`ifdef FULL_ADDER_OVERFLOW_EN
      check($sformatf("w1_ovf[%0d]", i), bus1.ovf, tab1[i].ovf);
`endif
      #9;
    end

    // WIDTH=8 directed boundary vectors
    for (int i = 0; i < 6; i++) begin
      bus8.a = tab8[i].a; bus8.b = tab8[i].b; bus8.c = tab8[i].c;
      #1;
      check($sformatf("w8_sum[%0d]", i), bus8.sum, tab8[i].sum);
      check($sformatf("w8_cout[%0d]", i), bus8.cout, tab8[i].cout);
`ifdef FULL_ADDER_OVERFLOW_EN
      check($sformatf("w8_ovf[%0d]", i), bus8.ovf, tab8[i].ovf);
`endif
      #9;
    end
    bus8.a = 8'h0; bus8.b = 8'h0; bus8.c = 1'b0;

    // Capture abc=011: result appears after the edge and not before
    @(negedge clk);
    bus1.a = 1'b0; bus1.b = 1'b1; bus1.c = 1'b1; bus1.in_valid = 1'b1;
    #1;
    check("pre_edge_valid", bus1.out_valid, 0);
    check("pre_edge_cout_q", bus1.cout_q, 0);
    @(posedge clk); #1;
    check("cap011_sum_q", bus1.sum_q, 0);
    check("cap011_cout_q", bus1.cout_q, 1);
    check("cap011_valid", bus1.out_valid, 1);

    // Capture abc=111, then drop in_valid: values hold, valid drops
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1;
    @(posedge clk); #1;
    check("cap111_sum_q", bus1.sum_q, 1);
    check("cap111_cout_q", bus1.cout_q, 1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0;
    @(posedge clk); #1;
    check("hold_sum_q", bus1.sum_q, 1);
    check("hold_cout_q", bus1.cout_q, 1);
    check("hold_valid", bus1.out_valid, 0);

    // Asynchronous reset mid-cycle while out_valid=1
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_valid", bus1.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum_q", bus1.sum_q, 0);
    check("async_rst_cout_q", bus1.cout_q, 0);
    check("async_rst_valid", bus1.out_valid, 0);
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b1;
    #1;
    check("rst_comb_sum", bus1.sum, 0);
    check("rst_comb_cout", bus1.cout, 1);
    @(posedge clk); #1;
    check("rst_hold_valid", bus1.out_valid, 0);
    check("rst_hold_cout_q", bus1.cout_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_sum_q", bus1.sum_q, 0);
    check("post_rst_cout_q", bus1.cout_q, 1);
    check("post_rst_valid", bus1.out_valid, 1);

    // Random WIDTH=8 vectors against a 9-bit reference and a register model
    exp_sq = 8'h0; exp_cq = 1'b0; exp_ovq = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      bus8.a = ra; bus8.b = rb; bus8.c = rc; bus8.in_valid = rv;
      #1;
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      exp_ovf = (ra[7] == rb[7]) && (ref9[7] != ra[7]);
      check("rand_comb", {bus8.cout, bus8.sum}, ref9);
`ifdef FULL_ADDER_OVERFLOW_EN
      check("rand_ovf", bus8.ovf, exp_ovf);
`endif
      @(posedge clk); #1;
      if (rv) begin
        exp_sq = ref9[7:0]; exp_cq = ref9[8]; exp_ovq = exp_ovf;
      end
      check("rand_reg", {bus8.cout_q, bus8.sum_q}, {exp_cq, exp_sq});
      check("rand_valid", bus8.out_valid, rv);
`ifdef FULL_ADDER_OVERFLOW_EN
      check("rand_ovf_q", bus8.ovf_q, exp_ovq);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
